elbeth_branch_predictor: RTL and testbench
==========================================

Name: elbeth_branch_predictor

Overview:
Parametrised dynamic branch predictor for the ELBETH fetch stage.
- Direct-mapped BTB with 2-bit saturating direction counters and a return-address stack (RAS).
- Predicts the next PC combinationally for IF. It is trained at ID by the resolved outcome from the branch unit.
- Flags mispredictions and supplies the redirect PC.
- Keeps performance counters.

Parameters:
XLEN, 32, datapath and PC width.
ENTRIES, 16, BTB entries; power of 2, >= 2; IDX = log2(ENTRIES).
RAS_DEPTH, 4, return-address stack entries; >= 1.
CNT_W, 32, width of the performance counters.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
if_pc  in  XLEN  fetch PC being looked up.
pred_taken  out  1  prediction for if_pc: taken (combinational).
pred_target  out  XLEN  predicted next PC (combinational).
upd_valid  in  1  resolved control-flow instruction present at ID.
upd_pc  in  XLEN  PC of the resolved instruction.
upd_kind  in  2  0 = conditional branch, 1 = plain jump, 2 = call, 3 = return.
upd_taken  in  1  resolved direction; always 1 for kinds 1-3.
upd_target  in  XLEN  resolved target.
upd_pred_taken  in  1  prediction that was made for this instruction, carried down the pipe.
upd_pred_target  in  XLEN  predicted next PC that was carried down the pipe.
mispredict  out  1  redirect required (combinational).
redirect_pc  out  XLEN  correct next PC: upd_taken ? upd_target : upd_pc+4.
stat_branches  out  CNT_W  count of upd_valid cycles.
stat_mispredicts  out  CNT_W  count of mispredict cycles.

Behaviour:
Indexing
- index = pc[IDX+1:2]; tag = pc[XLEN-1:IDX+2]; pc[1:0] ignored.
- Entry fields: valid, tag, target, kind, ctr[1:0].
- hit = valid && tag match.

Lookup (combinational, IF)
- Hit, kind 0: pred_taken = ctr[1]; pred_target = ctr[1] ? target : if_pc+4.
- Hit, kind 1 or 2: pred_taken = 1; pred_target = target.
- Hit, kind 3: pred_taken = 1; pred_target = RAS top if RAS is non-empty, else the stored target.
- Miss: pred_taken = 0; pred_target = if_pc+4. All additions are XLEN-bit and wrap.

Misprediction (combinational)
- mispredict = upd_valid && (upd_taken != upd_pred_taken || redirect_pc != upd_pred_target).
- mispredict is 0 whenever upd_valid = 0.

Update (rising edge, when upd_valid)
- Hit: overwrite kind. For kind 0, ctr moves +1 if taken and -1 if not, saturating at 0 and 3. If taken, overwrite target.
- Miss and taken: allocate the entry, replacing any existing one. Set valid, tag, target and kind. ctr = 2 for kind 0, ctr = 3 for kinds 1-3.
- Miss and not taken: no allocation.
- A same-cycle lookup of the same index sees the pre-update state (read-before-write).

RAS (non-speculative; updated at resolve)
- Kind 2: push upd_pc+4. When full, overwrite the oldest entry circularly; occupancy saturates at RAS_DEPTH.
- Kind 3: pop. Pop on empty has no effect.
- Stack pointer wraps modulo RAS_DEPTH.

Counters
- stat_branches increments on every upd_valid.
- stat_mispredicts increments on every mispredict.
- Both wrap at 2^CNT_W.

Reset
- Clears all valid bits, ctrs, RAS occupancy and stat counters immediately, including mid-operation.
- After reset: pred_taken = 0, pred_target = if_pc+4, stats = 0.
- The first edge after rst deasserts performs normal updates.

Test Plan:
1. After reset, if_pc=0x100 -> pred_taken=0, pred_target=0x104. Stats 0.
2. Conditional branch at 0x200 trained taken to 0x180. Update 1: mispredict=1, redirect_pc=0x180. Then if_pc=0x200 -> pred_taken=1, pred_target=0x180.
3. Counter saturation:
   - Same branch: 3 taken updates, then 2 not-taken -> prediction still taken after the 1st not-taken, not taken after the 2nd.
   - 5 more not-taken -> ctr holds at 0.
4. Aliasing with ENTRIES=16: 0x200 and 0x240 share index 0. Training 0x240 evicts 0x200 -> lookup 0x200 misses (pred_target=0x204).
5. RAS:
   - Call at 0x300 (target 0x800), then return at 0x810 -> lookup 0x810 predicts 0x304.
   - Five calls with RAS_DEPTH=4, then five returns -> four correct LIFO targets; the fifth return uses the stored BTB target.
6. Assert rst mid-stream with stats nonzero -> counters and predictions clear asynchronously, without waiting for an edge.
7. Simultaneous update and lookup of the same PC -> pred_* reflect the old entry.

Source files
------------

// File: rtl/elbeth_branch_predictor.sv
// ELBETH fetch-stage branch predictor: direct-mapped BTB with 2-bit
// direction counters, a non-speculative return-address stack, misprediction
// detection for the ID-stage resolve, and performance counters.
module elbeth_branch_predictor #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ENTRIES   = 16,
    parameter int unsigned RAS_DEPTH = 4,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  if_pc,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,
    input  logic             upd_valid,
    input  logic [XLEN-1:0]  upd_pc,
    input  logic [1:0]       upd_kind,
    input  logic             upd_taken,
    input  logic [XLEN-1:0]  upd_target,
    input  logic             upd_pred_taken,
    input  logic [XLEN-1:0]  upd_pred_target,
    output logic             mispredict,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispredicts
);

    localparam int unsigned IDX   = $clog2(ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX - 2;
    localparam int unsigned RP_W  = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned RC_W  = $clog2(RAS_DEPTH + 1);

    typedef enum logic [1:0] {
        KIND_BRANCH = 2'd0,
        KIND_JUMP   = 2'd1,
        KIND_CALL   = 2'd2,
        KIND_RET    = 2'd3
    } kind_e;

    // BTB storage
    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tags    [ENTRIES];
    logic [XLEN-1:0]    targets [ENTRIES];
    kind_e              kinds   [ENTRIES];
    logic [1:0]         ctrs    [ENTRIES];

    // RAS storage: ras_top addresses the most recent push
    logic [XLEN-1:0]    ras     [RAS_DEPTH];
    logic [RP_W-1:0]    ras_top;
    logic [RC_W-1:0]    ras_cnt;
    logic [RP_W-1:0]    ras_push_ptr;
    logic [RP_W-1:0]    ras_pop_ptr;

    // Lookup side
    logic [IDX-1:0]     lk_idx;
    logic [TAG_W-1:0]   lk_tag;
    logic               lk_hit;
    logic [XLEN-1:0]    lk_plus4;

    // Update side
    logic [IDX-1:0]     u_idx;
    logic [TAG_W-1:0]   u_tag;
    logic               u_hit;
    logic [XLEN-1:0]    u_plus4;
    kind_e              u_kind;

    assign lk_idx   = if_pc[IDX+1:2];
    assign lk_tag   = if_pc[XLEN-1:IDX+2];
    assign lk_hit   = valid[lk_idx] && (tags[lk_idx] == lk_tag);
    assign lk_plus4 = if_pc + XLEN'(4);

    assign u_idx    = upd_pc[IDX+1:2];
    assign u_tag    = upd_pc[XLEN-1:IDX+2];
    assign u_hit    = valid[u_idx] && (tags[u_idx] == u_tag);
    assign u_plus4  = upd_pc + XLEN'(4);
    assign u_kind   = kind_e'(upd_kind);

    // Circular pointer arithmetic modulo RAS_DEPTH (need not be a power of 2)
    assign ras_push_ptr = (ras_top == RP_W'(RAS_DEPTH - 1)) ? '0 : ras_top + RP_W'(1);
    assign ras_pop_ptr  = (ras_top == '0) ? RP_W'(RAS_DEPTH - 1) : ras_top - RP_W'(1);

    // Next-PC prediction for the fetch PC
    always_comb begin
        pred_taken  = 1'b0;
        pred_target = lk_plus4;
        if (lk_hit) begin
            case (kinds[lk_idx])
                KIND_BRANCH: begin
                    pred_taken  = ctrs[lk_idx][1];
                    pred_target = ctrs[lk_idx][1] ? targets[lk_idx] : lk_plus4;
                end
                KIND_JUMP, KIND_CALL: begin
                    pred_taken  = 1'b1;
                    pred_target = targets[lk_idx];
                end
                default: begin
                    pred_taken  = 1'b1;
                    pred_target = (ras_cnt != '0) ? ras[ras_top] : targets[lk_idx];
                end
            endcase
        end
    end

    // Resolve-time redirect and misprediction flag
    always_comb begin
        redirect_pc = upd_taken ? upd_target : u_plus4;
        mispredict  = upd_valid && ((upd_taken != upd_pred_taken) ||
                                    (redirect_pc != upd_pred_target));
    end

    // Valid bits and direction counters (cleared by reset)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ctrs[i] <= '0;
            end
        end else if (upd_valid) begin
            if (u_hit) begin
                if (u_kind == KIND_BRANCH) begin
                    if (upd_taken && ctrs[u_idx] != 2'd3) begin
                        ctrs[u_idx] <= ctrs[u_idx] + 2'd1;
                    end else if (!upd_taken && ctrs[u_idx] != 2'd0) begin
                        ctrs[u_idx] <= ctrs[u_idx] - 2'd1;
                    end
                end
            end else if (upd_taken) begin
                valid[u_idx] <= 1'b1;
                ctrs[u_idx]  <= (u_kind == KIND_BRANCH) ? 2'd2 : 2'd3;
            end
        end
    end

    // BTB payload (tag/target/kind); meaningless while the valid bit is clear
    always_ff @(posedge clk) begin
        if (upd_valid) begin
            if (u_hit) begin
                kinds[u_idx] <= u_kind;
                if (upd_taken) begin
                    targets[u_idx] <= upd_target;
                end
            end else if (upd_taken) begin
                tags[u_idx]    <= u_tag;
                targets[u_idx] <= upd_target;
                kinds[u_idx]   <= u_kind;
            end
        end
    end

    // RAS pointer and occupancy; a push when full overwrites the oldest slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ras_top <= RP_W'(RAS_DEPTH - 1);
            ras_cnt <= '0;
        end else if (upd_valid) begin
            if (u_kind == KIND_CALL) begin
                ras_top <= ras_push_ptr;
                if (ras_cnt != RC_W'(RAS_DEPTH)) begin
                    ras_cnt <= ras_cnt + RC_W'(1);
                end
            end else if (u_kind == KIND_RET && ras_cnt != '0) begin
                ras_top <= ras_pop_ptr;
                ras_cnt <= ras_cnt - RC_W'(1);
            end
        end
    end

    // RAS data: return address of each resolved call
    always_ff @(posedge clk) begin
        if (upd_valid && u_kind == KIND_CALL) begin
            ras[ras_push_ptr] <= u_plus4;
        end
    end

    // Performance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (upd_valid) begin
                stat_branches <= stat_branches + CNT_W'(1);
            end
            if (mispredict) begin
                stat_mispredicts <= stat_mispredicts + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_elbeth_branch_predictor.sv
// Directed-vector bench for elbeth_branch_predictor with hand-computed
// expected predictions, redirects and statistics.
module tb_elbeth_branch_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [1:0]  upd_kind;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    int n_vec;
    int n_err;
    int exp_br;
    int exp_mp;

    elbeth_branch_predictor #(
        .XLEN(32),
        .ENTRIES(16),
        .RAS_DEPTH(4),
        .CNT_W(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .if_pc(if_pc),
        .pred_taken(pred_taken),
        .pred_target(pred_target),
        .upd_valid(upd_valid),
        .upd_pc(upd_pc),
        .upd_kind(upd_kind),
        .upd_taken(upd_taken),
        .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target),
        .mispredict(mispredict),
        .redirect_pc(redirect_pc),
        .stat_branches(stat_branches),
        .stat_mispredicts(stat_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Lookup: drive if_pc and compare the combinational prediction
    task automatic lookup(input string tag, input logic [31:0] pc,
                          input logic exp_tk, input logic [31:0] exp_tgt);
        if_pc = pc;
        #1;
        check({tag, ".taken"}, {31'd0, pred_taken}, {31'd0, exp_tk});
        check({tag, ".target"}, pred_target, exp_tgt);
    endtask

    // One resolve cycle: check mispredict/redirect before the edge, then apply it
    task automatic resolve(input string tag, input logic [31:0] pc, input logic [1:0] kind,
                           input logic tk, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] ptgt,
                           input logic exp_mis, input logic [31:0] exp_redir);
        @(negedge clk);
        upd_valid       = 1'b1;
        upd_pc          = pc;
        upd_kind        = kind;
        upd_taken       = tk;
        upd_target      = tgt;
        upd_pred_taken  = ptk;
        upd_pred_target = ptgt;
        #1;
        check({tag, ".mispredict"}, {31'd0, mispredict}, {31'd0, exp_mis});
        check({tag, ".redirect"}, redirect_pc, exp_redir);
        exp_br++;
        if (exp_mis) exp_mp++;
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        #1;
        check({tag, ".idle_mispredict"}, {31'd0, mispredict}, 32'd0);
    endtask

    task automatic check_stats(input string tag);
        check({tag, ".stat_branches"}, stat_branches, exp_br);
        check({tag, ".stat_mispredicts"}, stat_mispredicts, exp_mp);
    endtask

    logic [31:0] call_pc [5];
    logic [31:0] ret_exp [4];

    initial begin
        n_vec = 0; n_err = 0; exp_br = 0; exp_mp = 0;
        rst = 1'b1;
        if_pc = 32'h100;
        upd_valid = 1'b0; upd_pc = '0; upd_kind = 2'd0; upd_taken = 1'b0;
        upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0;
        call_pc = '{32'h500, 32'h504, 32'h508, 32'h50C, 32'h520};
        ret_exp = '{32'h524, 32'h510, 32'h50C, 32'h508};

        // Reset state
        #12;
        lookup("reset", 32'h100, 1'b0, 32'h104);
        check_stats("reset");
        @(negedge clk);
        rst = 1'b0;

        // First training of a conditional branch: miss, taken -> allocate ctr=2
        resolve("br_alloc", 32'h200, 2'd0, 1'b1, 32'h180, 1'b0, 32'h204, 1'b1, 32'h180);
        lookup("br_after_alloc", 32'h200, 1'b1, 32'h180);

        // Saturation up: three taken updates, predicted correctly
        for (int i = 0; i < 3; i++)
            resolve("br_taken", 32'h200, 2'd0, 1'b1, 32'h180, 1'b1, 32'h180, 1'b0, 32'h180);
        resolve("br_nt1", 32'h200, 2'd0, 1'b0, 32'h180, 1'b1, 32'h180, 1'b1, 32'h204);
        lookup("br_after_nt1", 32'h200, 1'b1, 32'h180);
        resolve("br_nt2", 32'h200, 2'd0, 1'b0, 32'h180, 1'b1, 32'h180, 1'b1, 32'h204);
        lookup("br_after_nt2", 32'h200, 1'b0, 32'h204);
        // Saturation down: counter must stay at 0 (never wrap to 3)
        for (int i = 0; i < 5; i++) begin
            resolve("br_nt_more", 32'h200, 2'd0, 1'b0, 32'h180, 1'b0, 32'h204, 1'b0, 32'h204);
            lookup("br_hold0", 32'h200, 1'b0, 32'h204);
        end
        check_stats("after_branch");

        // Aliasing: 0x240 shares index 0 with 0x200 and evicts it
        resolve("alias_jmp", 32'h240, 2'd1, 1'b1, 32'h900, 1'b0, 32'h244, 1'b1, 32'h900);
        lookup("alias_evicted", 32'h200, 1'b0, 32'h204);
        lookup("alias_new", 32'h240, 1'b1, 32'h900);

        // Same-cycle update and lookup: prediction reflects the old entry
        @(negedge clk);
        if_pc           = 32'h240;
        upd_valid       = 1'b1;
        upd_pc          = 32'h240;
        upd_kind        = 2'd1;
        upd_taken       = 1'b1;
        upd_target      = 32'h940;
        upd_pred_taken  = 1'b1;
        upd_pred_target = 32'h900;
        #1;
        check("rbw.pred_target", pred_target, 32'h900);
        check("rbw.mispredict", {31'd0, mispredict}, 32'd1);
        exp_br++; exp_mp++;
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        lookup("rbw_after", 32'h240, 1'b1, 32'h940);

        // RAS: train the return at 0x810, then call at 0x300 and return
        resolve("ret_train", 32'h810, 2'd3, 1'b1, 32'h110, 1'b0, 32'h814, 1'b1, 32'h110);
        resolve("call_300", 32'h300, 2'd2, 1'b1, 32'h800, 1'b0, 32'h304, 1'b1, 32'h800);
        lookup("ret_pred", 32'h810, 1'b1, 32'h304);
        resolve("ret_304", 32'h810, 2'd3, 1'b1, 32'h304, 1'b1, 32'h304, 1'b0, 32'h304);

        // Five calls into a 4-deep RAS, then five returns
        for (int i = 0; i < 5; i++)
            resolve("call_n", call_pc[i], 2'd2, 1'b1, 32'h800, 1'b0, call_pc[i] + 32'd4,
                    1'b1, 32'h800);
        for (int i = 0; i < 4; i++) begin
            lookup("ras_lifo", 32'h810, 1'b1, ret_exp[i]);
            resolve("ret_n", 32'h810, 2'd3, 1'b1, ret_exp[i], 1'b1, ret_exp[i], 1'b0, ret_exp[i]);
        end
        // RAS empty: falls back to the stored BTB target (last trained 0x508)
        lookup("ras_empty", 32'h810, 1'b1, 32'h508);
        resolve("ret_last", 32'h810, 2'd3, 1'b1, 32'h504, 1'b1, 32'h508, 1'b1, 32'h504);
        check_stats("after_ras");

        // Asynchronous reset mid-cycle, away from any clock edge
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst.stat_branches", stat_branches, 32'd0);
        check("async_rst.stat_mispredicts", stat_mispredicts, 32'd0);
        lookup("async_rst", 32'h810, 1'b0, 32'h814);
        exp_br = 0; exp_mp = 0;
        @(negedge clk);
        rst = 1'b0;

        // First edge after reset performs a normal update; not-taken does not allocate
        resolve("post_rst", 32'h200, 2'd0, 1'b0, 32'h180, 1'b0, 32'h204, 1'b0, 32'h204);
        lookup("post_rst_miss", 32'h200, 1'b0, 32'h204);
        check_stats("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
